// File: rtl/obstacle_pkg.sv
// obstacle_pkg: shared types and constants for the scrolling obstacle field.
//   state_t      - game FSM states
//   seg_t        - one 7-segment digit {g,f,e,d,c,b,a}
//   *_PAT, BLANK - digit patterns used by the field
//   table_pat()  - maps a 3-bit random index to a new digit pattern
//   is_obstacle() - anything that is neither bonus nor blank is an obstacle
package obstacle_pkg;

    typedef enum logic [1:0] {IDLE, RUN, LOSE, WIN} state_t;

    typedef logic [6:0] seg_t;

    localparam seg_t OBS_PAT0  = 7'h01;
    localparam seg_t OBS_PAT1  = 7'h40;
    localparam seg_t OBS_PAT2  = 7'h08;
    localparam seg_t OBS_PAT3  = 7'h49;
    localparam seg_t BONUS_PAT = 7'h63;
    localparam seg_t BLANK     = 7'h00;

    // Indices 5..7 are blank so empty digits dominate the random stream.
    function automatic seg_t table_pat(input logic [2:0] idx);
        case (idx)
            3'd0:    return OBS_PAT0;
            3'd1:    return OBS_PAT1;
            3'd2:    return OBS_PAT2;
            3'd3:    return OBS_PAT3;
            3'd4:    return BONUS_PAT;
            default: return BLANK;
        endcase
    endfunction

    function automatic logic is_obstacle(input seg_t p);
        return (p != BONUS_PAT) && (p != BLANK);
    endfunction

endpackage

// File: rtl/obstacle_field_if.sv
// obstacle_field_if: inject handshake into the obstacle field.
//   inject_valid - producer has a pattern to force into the next inserted digit
//   inject_pat   - the forced pattern
//   inject_ready - field has no pattern pending
// master = producer (testbench / game controller), slave = obstacle_field.
interface obstacle_field_if;
    import obstacle_pkg::*;

    logic inject_valid;
    seg_t inject_pat;
    logic inject_ready;

    modport master (output inject_valid, output inject_pat, input inject_ready);
    modport slave  (input inject_valid, input inject_pat, output inject_ready);
endinterface

// File: rtl/obstacle_lfsr.sv
// obstacle_lfsr: free-running 8-bit Fibonacci LFSR (taps 8,6,5,4).
//   clk, rst - clock, synchronous active-high reset (loads SEED)
//   idx      - low three state bits, used as the random pattern index
// Advances every cycle regardless of game state.
module obstacle_lfsr #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    output logic [2:0] idx
);

    logic [7:0] q;

    always_ff @(posedge clk) begin
        if (rst) q <= SEED;
        else     q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    end

    assign idx = q[2:0];

endmodule

// File: rtl/obstacle_field.sv
// obstacle_field: scrolling obstacle field of a 7-segment runner game.
//   clk, rst     - clock, synchronous active-high reset
//   start        - pulse; starts a run from IDLE/LOSE/WIN
//   hero         - hero segments, checked against the digit leaving the field
//   inj          - inject handshake (slave side)
//   field        - DIGITS digits, digit 0 (bits [6:0]) is next to the hero
//   world        - current world index
//   scroll_tick  - pulse on each scroll step
//   bonus_taken  - pulse the cycle after a bonus overlaps the hero
//   lose, win    - level outputs of the terminal states
module obstacle_field
    import obstacle_pkg::*;
#(
    parameter int         DIGITS        = 3,
    parameter int         WORLDS        = 4,
    parameter int         OBS_PER_WORLD = 8,
    parameter int         TICK_DIV      = 25_000_000,
    parameter logic [7:0] SEED          = 8'hA5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  seg_t                hero,
    obstacle_field_if.slave     inj,
    output logic [DIGITS*7-1:0] field,
    output logic [1:0]          world,
    output logic                scroll_tick,
    output logic                bonus_taken,
    output logic                lose,
    output logic                win
);

    localparam int DIV_W = $clog2(TICK_DIV + 1);

    state_t           state, state_nx;
    logic [DIV_W-1:0] div_cnt;
    logic [31:0]      div_term;
    logic [7:0]       pass_cnt;
    seg_t             last_pat;
    logic             pend_vld;
    seg_t             pend_pat;
    logic [2:0]       rnd_idx;

    logic enter_run, tick, xfer;
    seg_t exit_pat, new_pat;
    logic exit_obs, exit_hit, pass_evt, world_done, last_world;

    obstacle_lfsr #(.SEED(SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .idx (rnd_idx)
    );

    // Each world halves the scroll period.
    assign div_term    = 32'((TICK_DIV >> world) - 1);
    assign tick        = (state == RUN) && (div_cnt == DIV_W'(div_term));
    assign scroll_tick = tick;

    assign enter_run  = start && (state != RUN);
    assign xfer       = inj.inject_valid && inj.inject_ready;
    assign inj.inject_ready = !pend_vld;

    assign exit_pat   = field[6:0];
    assign exit_obs   = is_obstacle(exit_pat);
    assign exit_hit   = |(exit_pat & hero);
    assign pass_evt   = tick && exit_obs && !exit_hit;
    assign world_done = pass_evt && (pass_cnt == 8'(OBS_PER_WORLD - 1));
    assign last_world = (world == 2'(WORLDS - 1));

    // A non-blank insert is always followed by a blank unless something is
    // injected, so obstacles never arrive back-to-back on their own.
    always_comb begin
        new_pat = table_pat(rnd_idx);
        if (pend_vld)              new_pat = pend_pat;
        else if (last_pat != BLANK) new_pat = BLANK;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            RUN: begin
                if (tick && exit_obs && exit_hit)  state_nx = LOSE;
                else if (world_done && last_world) state_nx = WIN;
            end
            default: if (start) state_nx = RUN;
        endcase
    end

    assign lose = (state == LOSE);
    assign win  = (state == WIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            field       <= '0;
            world       <= '0;
            div_cnt     <= '0;
            pass_cnt    <= '0;
            last_pat    <= BLANK;
            pend_vld    <= 1'b0;
            pend_pat    <= BLANK;
            bonus_taken <= 1'b0;
        end else begin
            bonus_taken <= tick && (exit_pat == BONUS_PAT) && exit_hit;
            if (enter_run) begin
                // A transfer coinciding with the start is dropped with the
                // rest of the previous run's leftovers.
                field    <= '0;
                world    <= '0;
                div_cnt  <= '0;
                pass_cnt <= '0;
                last_pat <= BLANK;
                pend_vld <= 1'b0;
            end else begin
                if (state == RUN) begin
                    div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
                    if (tick) begin
                        field    <= {new_pat, field[DIGITS*7-1:7]};
                        last_pat <= new_pat;
                    end
                    if (pass_evt) begin
                        if (world_done) begin
                            pass_cnt <= '0;
                            if (!last_world) world <= world + 2'd1;
                        end else begin
                            pass_cnt <= pass_cnt + 8'd1;
                        end
                    end
                end
                // Transfer only happens while nothing is pending, so it
                // cannot collide with a consumption of the same slot.
                if (xfer) begin
                    pend_vld <= 1'b1;
                    pend_pat <= inj.inject_pat;
                end else if (tick && pend_vld) begin
                    pend_vld <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_obstacle_field.sv
// tb_obstacle_field: randomized scoreboard bench for obstacle_field.
// A behavioural model tracks the game as a list of digits plus the cycle
// number of the next scroll step; each scroll step it predicts is queued and
// a monitor on the falling edge pairs it with the DUT's scroll_tick.
module tb_obstacle_field;

    localparam int         DIGITS   = 3;
    localparam int         WORLDS   = 2;
    localparam int         OBS      = 2;
    localparam int         TICK_DIV = 8;
    localparam logic [7:0] SEED     = 8'hA5;

    localparam int ST_IDLE = 0, ST_RUN = 1, ST_LOSE = 2, ST_WIN = 3;

    logic                clk = 1'b0;
    logic                rst, start;
    logic [6:0]          hero;
    logic [DIGITS*7-1:0] field;
    logic [1:0]          world;
    logic                scroll_tick, bonus_taken, lose, win;

    obstacle_field_if inj ();

    obstacle_field #(
        .DIGITS(DIGITS), .WORLDS(WORLDS), .OBS_PER_WORLD(OBS),
        .TICK_DIV(TICK_DIV), .SEED(SEED)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .hero(hero), .inj(inj),
        .field(field), .world(world), .scroll_tick(scroll_tick),
        .bonus_taken(bonus_taken), .lose(lose), .win(win)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_err = 0;
    int tick_cnt = 0, bonus_cnt = 0;
    bit chk_en = 0, feed_rand = 0;
    logic [6:0] feed_q[$];

    // ---------------- reference model ----------------
    typedef struct { int edge_no; logic [DIGITS*7-1:0] fld; } tick_t;
    tick_t tq[$];

    int         m_cyc = 0, m_state = ST_IDLE, m_next_tick = 0;
    int         m_world = 0, m_pass = 0;
    logic [6:0] m_field[DIGITS];
    logic [6:0] m_last = 0, m_pend = 0;
    bit         m_pend_vld = 0, m_bonus = 0;
    logic [7:0] m_lfsr = SEED;

    function automatic logic [6:0] pat_of(input logic [2:0] i);
        logic [6:0] t[8] = '{7'h01, 7'h40, 7'h08, 7'h49, 7'h63, 7'h00, 7'h00, 7'h00};
        return t[i];
    endfunction

    function automatic logic [DIGITS*7-1:0] pack_field();
        logic [DIGITS*7-1:0] r;
        for (int i = 0; i < DIGITS; i++) r[i*7 +: 7] = m_field[i];
        return r;
    endfunction

    task automatic model_step();
        logic [7:0] l_old;
        logic [6:0] p, np;
        bit         tk, xf;
        m_cyc++;
        m_bonus = 0;
        if (rst) begin
            m_state = ST_IDLE; m_world = 0; m_pass = 0; m_last = 0;
            m_pend_vld = 0; m_lfsr = SEED;
            for (int i = 0; i < DIGITS; i++) m_field[i] = 0;
            return;
        end
        l_old  = m_lfsr;
        m_lfsr = {l_old[6:0], l_old[7] ^ l_old[5] ^ l_old[4] ^ l_old[3]};
        tk = (m_state == ST_RUN) && (m_cyc == m_next_tick);
        xf = inj.inject_valid && !m_pend_vld;
        if (start && m_state != ST_RUN) begin
            m_state = ST_RUN; m_world = 0; m_pass = 0; m_last = 0;
            m_pend_vld = 0; m_next_tick = m_cyc + TICK_DIV;
            for (int i = 0; i < DIGITS; i++) m_field[i] = 0;
            return;
        end
        if (tk) begin
            p = m_field[0];
            if (m_pend_vld) begin np = m_pend; m_pend_vld = 0; end
            else if (m_last != 0) np = 0;
            else np = pat_of(l_old[2:0]);
            m_last = np;
            for (int i = 0; i < DIGITS - 1; i++) m_field[i] = m_field[i+1];
            m_field[DIGITS-1] = np;
            if (p != 7'h00 && p != 7'h63) begin
                if ((p & hero) != 0) m_state = ST_LOSE;
                else begin
                    m_pass++;
                    if (m_pass == OBS) begin
                        m_pass = 0;
                        if (m_world == WORLDS - 1) m_state = ST_WIN;
                        else m_world++;
                    end
                end
            end else if (p == 7'h63 && (p & hero) != 0) begin
                m_bonus = 1;
            end
            m_next_tick = m_cyc + (TICK_DIV >> m_world);
            tq.push_back('{m_cyc, pack_field()});
        end
        if (xf) begin m_pend_vld = 1; m_pend = inj.inject_pat; end
    endtask

    initial begin
        for (int i = 0; i < DIGITS; i++) m_field[i] = 0;
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 30)
                $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, m_cyc);
        end
    endtask

    initial begin : monitor
        bit    seen = 0;
        tick_t e;
        forever begin
            @(negedge clk);
            if (!chk_en) begin
                tq.delete();
                seen = 0;
            end else begin
                check("scroll_tick", 32'(scroll_tick),
                      32'((m_state == ST_RUN) && (m_next_tick == m_cyc + 1)));
                if (seen) begin
                    if (tq.size() == 0) check("tick_expected", 32'(0), 32'(1));
                    else begin
                        e = tq.pop_front();
                        check("tick_edge", 32'(e.edge_no), 32'(m_cyc));
                        check("tick_field", 32'(field), 32'(e.fld));
                    end
                end else if (tq.size() != 0) begin
                    check("tick_missing", 32'(tq.size()), 32'(0));
                    tq.delete();
                end
                seen = scroll_tick;
                if (scroll_tick) tick_cnt++;
                if (bonus_taken) bonus_cnt++;
                check("field", 32'(field), 32'(pack_field()));
                check("world", 32'(world), 32'(m_world));
                check("lose", 32'(lose), 32'(m_state == ST_LOSE));
                check("win", 32'(win), 32'(m_state == ST_WIN));
                check("bonus_taken", 32'(bonus_taken), 32'(m_bonus));
                check("inject_ready", 32'(inj.inject_ready), 32'(!m_pend_vld));
            end
        end
    end

    // ---------------- inject driver ----------------
    function automatic logic [6:0] rand_pat();
        logic [6:0] r;
        r = 7'($urandom);
        case ($urandom_range(0, 6))
            0: r = 7'h01;
            1: r = 7'h40;
            2: r = 7'h08;
            3: r = 7'h49;
            4: r = 7'h63;
            5: r = 7'h00;
            default: ;
        endcase
        return r;
    endfunction

    function automatic logic [6:0] pick_hero();
        logic [6:0] r;
        r = 7'($urandom);
        case ($urandom_range(0, 4))
            0: r = 7'h00;
            1: r = 7'h01;
            2: r = 7'h40;
            3: r = 7'h08;
            default: ;
        endcase
        return r;
    endfunction

    initial begin : feeder
        inj.inject_valid = 1'b0;
        inj.inject_pat   = 7'h00;
        forever begin
            @(negedge clk);
            if (inj.inject_ready && feed_q.size() != 0) begin
                inj.inject_valid = 1'b1;
                inj.inject_pat   = feed_q.pop_front();
            end else if (feed_rand && $urandom_range(0, 3) == 0) begin
                // Also asserts valid while not ready, which must be ignored.
                inj.inject_valid = 1'b1;
                inj.inject_pat   = rand_pat();
            end else begin
                inj.inject_valid = 1'b0;
                inj.inject_pat   = 7'($urandom);
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        int base;
        rst = 1'b1; start = 1'b0; hero = 7'h00;
        repeat (2) @(negedge clk);
        chk_en = 1;
        rst = 1'b0;

        // Idle after reset: nothing moves.
        repeat (40) @(negedge clk);
        check("idle_ticks", 32'(tick_cnt), 32'(0));
        check("idle_field", 32'(field), 32'(0));
        check("idle_world", 32'(world), 32'(0));

        // Four clean passes: two worlds, then a win.
        hero = 7'h00;
        pulse_start();
        feed_q.push_back(7'h01); feed_q.push_back(7'h40);
        feed_q.push_back(7'h08); feed_q.push_back(7'h49);
        repeat (120) @(negedge clk);
        check("win_level", 32'(win), 32'(1));
        check("win_world", 32'(world), 32'(1));
        base = tick_cnt;
        repeat (30) @(negedge clk);
        check("win_frozen", 32'(tick_cnt - base), 32'(0));

        // Collision: obstacle 01 against hero 01.
        hero = 7'h01;
        pulse_start();
        feed_q.push_back(7'h01);
        repeat (40) @(negedge clk);
        check("lose_level", 32'(lose), 32'(1));
        base = tick_cnt;
        repeat (50) @(negedge clk);
        check("lose_frozen", 32'(tick_cnt - base), 32'(0));

        // Bonus pickup: 63 against hero 40.
        hero = 7'h40;
        pulse_start();
        feed_q.push_back(7'h63);
        base = bonus_cnt;
        repeat (35) @(negedge clk);
        check("bonus_count", 32'(bonus_cnt - base), 32'(1));
        check("bonus_no_lose", 32'(lose), 32'(0));

        // Randomized play.
        feed_rand = 1;
        for (int it = 0; it < 10; it++) begin
            hero = pick_hero();
            pulse_start();
            for (int c = 0; c < 200; c++) begin
                @(negedge clk);
                if ($urandom_range(0, 19) == 0) hero = pick_hero();
                if ($urandom_range(0, 39) == 0) feed_q.push_back(rand_pat());
                start = ($urandom_range(0, 99) == 0);
            end
            start = 1'b0;
        end
        feed_rand = 0;
        feed_q.delete();

        // Reset mid-run with an inject pending; reset wins over start.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        hero = 7'h00;
        pulse_start();
        feed_q.push_back(7'h49);
        repeat (3) @(negedge clk);
        check("pend_before_rst", 32'(inj.inject_ready), 32'(0));
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        check("rst_field", 32'(field), 32'(0));
        check("rst_world", 32'(world), 32'(0));
        check("rst_ready", 32'(inj.inject_ready), 32'(1));
        check("rst_flags", 32'({scroll_tick, bonus_taken, lose, win}), 32'(0));
        rst = 1'b0; start = 1'b0;
        base = tick_cnt;
        repeat (20) @(negedge clk);
        check("rst_idle_ticks", 32'(tick_cnt - base), 32'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
